// File: rtl/jk_excitation_sequencer_pkg.sv
// Shared types for the JK excitation sequencer: FSM state encoding and mode codes.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic MODE_JUMP = 1'b0;
  localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation: for each bit, drive the (J,K) pair that moves Q to N.
// Never produces the toggle code, so the bank result does not depend on its current value.
module jk_excite #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = ~q & n;
    k = q & ~n;
  end

endmodule

// File: rtl/jk_excitation_sequencer.sv
// Moves an external JK flip-flop bank to a requested value (jump or +/-1 steps),
// verifying the fed-back Q after every step; reports done or a sticky error.
module jk_excitation_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             MODE,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] EXPECT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR
);

  state_t           state;
  logic [WIDTH-1:0] tgt_q;
  logic             mode_q;
  logic [WIDTH-1:0] tgt_sel;
  logic             mode_sel;
  logic [WIDTH-1:0] n_nxt;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;

  // Unsigned, non-wrapping move toward the target; in jump mode go straight there.
  function automatic logic [WIDTH-1:0] next_value(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] tgt,
                                                  input logic             mode);
    if (mode == MODE_JUMP)
      return tgt;
    else if (q < tgt)
      return WIDTH'(q + 1'b1);
    else if (q > tgt)
      return WIDTH'(q - 1'b1);
    else
      return q;
  endfunction

  // In IDLE the request has not been latched yet, so use the live inputs.
  always_comb begin
    tgt_sel  = (state == ST_IDLE) ? TARGET : tgt_q;
    mode_sel = (state == ST_IDLE) ? MODE   : mode_q;
    n_nxt    = next_value(Q_FB, tgt_sel, mode_sel);
  end

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q (Q_FB),
    .n (n_nxt),
    .j (j_c),
    .k (k_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      tgt_q  <= '0;
      mode_q <= MODE_JUMP;
      J      <= '0;
      K      <= '0;
      EXPECT <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERROR  <= 1'b0;
    end else begin
      J    <= '0;
      K    <= '0;
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          BUSY <= 1'b0;
          if (START) begin
            tgt_q  <= TARGET;
            mode_q <= MODE;
            if (Q_FB == TARGET) begin
              state <= ST_DONE;
              DONE  <= 1'b1;
            end else begin
              state  <= ST_DRIVE;
              J      <= j_c;
              K      <= k_c;
              EXPECT <= n_nxt;
              BUSY   <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (Q_FB != EXPECT) begin
            state <= ST_ERR;
            ERROR <= 1'b1;
            BUSY  <= 1'b0;
          end else if (Q_FB == tgt_q) begin
            state <= ST_DONE;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end else begin
            state  <= ST_DRIVE;
            J      <= j_c;
            K      <= k_c;
            EXPECT <= n_nxt;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_ERR: begin
          BUSY <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Bench for jk_excitation_sequencer: a behavioural JK bank closes the loop, and a
// queue of expected per-step values is consumed as the DUT drives each step.
module tb_jk_excitation_sequencer;

  localparam int WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [WIDTH-1:0] TARGET = '0;
  logic             MODE = 1'b0;
  logic [WIDTH-1:0] Q_FB;
  logic [WIDTH-1:0] J, K, EXPECT;
  logic             BUSY, DONE, ERROR;

  logic [WIDTH-1:0] bank;
  logic             preset_en = 1'b0;
  logic [WIDTH-1:0] preset_val = '0;
  logic             stuck0 = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  jk_excitation_sequencer #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .TARGET (TARGET),
    .MODE   (MODE),
    .Q_FB   (Q_FB),
    .J      (J),
    .K      (K),
    .EXPECT (EXPECT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERROR  (ERROR)
  );

  assign Q_FB = bank;

  // Behavioural bank of JK flip-flops; bit 0 can be forced stuck at 0.
  always_ff @(posedge CLK) begin
    if (preset_en) begin
      bank <= preset_val;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({J[i], K[i]})
          2'b00: bank[i] <= bank[i];
          2'b01: bank[i] <= 1'b0;
          2'b10: bank[i] <= 1'b1;
          default: bank[i] <= ~bank[i];
        endcase
      end
      if (stuck0) bank[0] <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic preset_bank(input logic [WIDTH-1:0] v);
    @(negedge CLK);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge CLK);
    preset_en  = 1'b0;
  endtask

  // Run one request; poke=1 re-pulses START (TARGET=15) while the DUT is busy.
  task automatic run_txn(input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] tgt,
                         input logic mode, input bit poke);
    logic [WIDTH-1:0] q, n, jx, kx;
    int  exp_done;
    bit  seen;
    int  extra;
    preset_bank(b0);
    exp_q.delete();
    q = b0;
    exp_done = 1;
    if (q != tgt) begin
      if (mode == 1'b0) begin
        exp_q.push_back(tgt);
        exp_done = 3;
      end else begin
        while (q != tgt) begin
          q = (q < tgt) ? q + 4'd1 : q - 4'd1;
          exp_q.push_back(q);
        end
        exp_done = 2 * exp_q.size() + 1;
      end
    end
    @(negedge CLK);
    START = 1'b1; TARGET = tgt; MODE = mode;
    @(posedge CLK);
    #1;
    START = 1'b0; TARGET = ~tgt; MODE = ~mode;
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge CLK);
      if (poke && c == 2) begin START = 1'b1; TARGET = 4'd15; end
      else if (poke && c == 3) START = 1'b0;
      if ((J | K) != '0) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_drive", {28'd0, J | K}, 32'd0);
        end else begin
          n  = exp_q.pop_front();
          jx = ~bank & n;
          kx = bank & ~n;
          check_val("expect", EXPECT, n);
          check_val("j_drive", J, jx);
          check_val("k_drive", K, kx);
          check_val("busy_in_drive", BUSY, 1);
        end
      end
      if (DONE) begin
        seen = 1;
        check_val("done_cycle", c, exp_done);
        check_val("bank_final", bank, tgt);
        check_val("leftover_steps", exp_q.size(), 0);
      end
    end
    if (!seen) check_val("done_timeout", 0, 1);
    START = 1'b0;
    if (poke) begin
      extra = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge CLK);
        if (DONE) extra++;
      end
      check_val("second_done", extra, 0);
      check_val("bank_kept", bank, tgt);
    end
  endtask

  initial begin
    // Reset state while RST held
    #12;
    check_val("rst_j", J, 0);
    check_val("rst_k", K, 0);
    check_val("rst_expect", EXPECT, 0);
    check_val("rst_flags", {29'd0, BUSY, DONE, ERROR}, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Reset asserted mid-DRIVE clears J/K immediately, bank untouched
    preset_bank(4'd0);
    @(negedge CLK);
    START = 1'b1; TARGET = 4'b1010; MODE = 1'b0;
    @(posedge CLK);
    #1 START = 1'b0;
    @(negedge CLK);
    check_val("pre_rst_j", J, 4'b1010);
    #2 RST = 1'b1;
    #1;
    check_val("midrst_j", J, 0);
    check_val("midrst_k", K, 0);
    check_val("midrst_expect", EXPECT, 0);
    check_val("midrst_busy", BUSY, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_val("bank_after_rst", bank, 0);

    // Jump, step up, step down, step from zero, already at target, ignored START
    run_txn(4'd0,  4'b1010, 1'b0, 0);
    run_txn(4'd3,  4'd6,    1'b1, 0);
    run_txn(4'd6,  4'd1,    1'b1, 0);
    run_txn(4'd0,  4'd3,    1'b1, 0);
    run_txn(4'd15, 4'd13,   1'b1, 0);
    run_txn(4'd9,  4'd9,    1'b0, 0);
    run_txn(4'd9,  4'd9,    1'b1, 0);
    run_txn(4'd3,  4'd6,    1'b1, 1);
    run_txn(4'd5,  4'b0110, 1'b0, 0);

    // Stuck feedback bit: jump 0 -> 1 must end in sticky ERROR
    preset_bank(4'd0);
    stuck0 = 1'b1;
    @(negedge CLK);
    START = 1'b1; TARGET = 4'd1; MODE = 1'b0;
    @(posedge CLK);
    #1 START = 1'b0;
    @(negedge CLK);
    check_val("fault_drive_j", J, 4'd1);
    check_val("fault_expect", EXPECT, 4'd1);
    @(negedge CLK);
    check_val("fault_err_in_check", ERROR, 0);
    @(negedge CLK);
    check_val("fault_err", ERROR, 1);
    check_val("fault_busy", BUSY, 0);
    START = 1'b1; TARGET = 4'd0; MODE = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check_val("err_sticky", {30'd0, ERROR, DONE}, 32'd2);
    end
    RST = 1'b1;
    #1;
    check_val("err_cleared", ERROR, 0);
    @(negedge CLK);
    RST = 1'b0;
    stuck0 = 1'b0;
    run_txn(4'd0, 4'd1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jk_excitation_sequencer.md
# jk_excitation_sequencer

Drives a bank of WIDTH external `jk_flipflop` instances. It is the inverse direction of the flip-flop: the flip-flop maps (J,K,Q) to next Q, and this block maps (current Q, desired Q) to J,K. It accepts a target value on a START strobe, moves the bank to the target (in one jump or in ±1 steps), and checks the fed-back Q after every step. It reports done or a sticky error.

## Interface
- WIDTH, 4, number of JK flip-flops in the driven bank (≥1).
- CLK  input  1  clock, rising-edge; same clock as the JK bank.
- RST  input  1  reset; asynchronous, active-high.
- START  input  1  one-cycle request; sampled only in IDLE.
- TARGET  input  WIDTH  desired final bank value; latched when START is accepted.
- MODE  input  1  0 = jump directly to target; 1 = step ±1 per step toward target. Latched with START.
- Q_FB  input  WIDTH  Q outputs of the JK bank.
- J  output  WIDTH  per-bit J drive to the bank, registered.
- K  output  WIDTH  per-bit K drive to the bank, registered.
- EXPECT  output  WIDTH  value the bank must hold after the current step, registered.
- BUSY  output  1  high in DRIVE and CHECK.
- DONE  output  1  one-cycle pulse when the bank equals the target.
- ERROR  output  1  sticky; high when feedback mismatched EXPECT.

## Operation
- Excitation rule, per bit, with Q = Q_FB and N = next value: J = ~Q & N, K = Q & ~N.
  - Hold-0 and hold-1 both give 00.
  - The toggle code 11 is never issued.
- States: IDLE, DRIVE, CHECK, DONE, ERR.
- IDLE: J = K = 0, BUSY = 0.
  - START=1 latches TARGET and MODE.
  - If Q_FB == TARGET, go to DONE.
  - Otherwise compute N and go to DRIVE.
- Computing N:
  - MODE = 0: N = TARGET.
  - MODE = 1: N = Q_FB + 1 if Q_FB < target; N = Q_FB − 1 if Q_FB > target.
  - Comparisons are unsigned. No wrap-around: stepping from 0 toward 15 counts up, never passes through 0−1.
- DRIVE (one cycle): J/K hold the excitation for (Q_FB at entry, N). EXPECT = N. The bank captures on the rising edge that ends DRIVE. Next state is CHECK.
- CHECK (one cycle): J = K = 0.
  - Q_FB ≠ EXPECT: go to ERR.
  - Q_FB == target: go to DONE.
  - Otherwise compute the next N and go to DRIVE.
- DONE: DONE = 1 for exactly one cycle, J = K = 0, then IDLE.
- ERR: ERROR = 1, J = K = 0, BUSY = 0. START is ignored. Only RST exits ERR.
- START outside IDLE is ignored. No queueing. A TARGET change mid-operation has no effect.

## Timing
- Reset values (asynchronous, immediate): state = IDLE, J = 0, K = 0, EXPECT = 0, BUSY = 0, DONE = 0, ERROR = 0, latched target = 0, latched mode = 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Cycle counts, with START sampled at edge 0:
  - Jump mode: DRIVE in cycle 1, CHECK in cycle 2, DONE in cycle 3.
  - Step mode with distance d: DONE in cycle 2d+1.
  - Already at target: DONE in cycle 1.
- J/K are stable for the whole DRIVE cycle and are 0 in every other state. The bank therefore changes only on the edge ending DRIVE.
- RST mid-DRIVE forces J = K = 0 immediately. The bank's state is left as-is.
- START and RST together: RST wins.

## Structure
- Package `jk_seq_pkg`:
  - State enum (3-bit encoding: IDLE = 0, DRIVE = 1, CHECK = 2, DONE = 3, ERR = 4).
  - MODE_JUMP = 0, MODE_STEP = 1.
- Sub-module `jk_excite`: parameterised WIDTH, purely combinational (Q, N) → (J, K). It is reusable by other JK-based counters.
- The sequencer owns the FSM, the next-value computation and the registers.
- Bench: WIDTH `jk_flipflop` instances on CLK, with Q wired to Q_FB and J/K driven by the DUT.

## Test plan
- Reset: assert RST mid-cycle → J = K = 0, EXPECT = 0, all flags low immediately. Release → IDLE.
- Jump: bank = 0, START with TARGET = 4'b1010, MODE = 0 → in DRIVE, J = 1010 and K = 0000. DONE pulses in cycle 3, bank = 1010.
- Step up/down:
  - bank = 3, TARGET = 6, MODE = 1 → EXPECT sequence 4, 5, 6, DONE in cycle 7.
  - Then TARGET = 1 → EXPECT sequence 5, 4, 3, 2, 1, no wrap.
- Already at target: bank = 9, START with TARGET = 9 → DONE in cycle 1, J/K never nonzero.
- Fault: force Q_FB bit 0 stuck at 0, jump 0 → 1 → ERR after CHECK, ERROR sticky. Extra START is ignored. RST clears it.
- Ignored START: pulse START with TARGET = 15 while BUSY during a step sequence → original target still reached, no second DONE.
